// File: rtl/fb_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Package  : fb_pkg
// Brief    : Frame-buffer geometry, bus widths and RGB565 field slices shared
//            by the BRAM arbiter, its scan address generator and its interface.
// Revision : 1.0 - initial release
// ============================================================================
package fb_pkg;

   // Frame geometry (active area only) and BRAM word count
   localparam int HSIZE    = 640;
   localparam int VSIZE    = 480;
   localparam int FB_WORDS = HSIZE * VSIZE;

   // BRAM bus widths; FB_WORDS must fit in 2**ADDR_W
   localparam int ADDR_W   = 19;
   localparam int DATA_W   = 16;

   // RGB565 field positions inside one pixel word
   localparam int RGB_R_MSB = 15;
   localparam int RGB_R_LSB = 11;
   localparam int RGB_G_MSB = 10;
   localparam int RGB_G_LSB = 5;
   localparam int RGB_B_MSB = 4;
   localparam int RGB_B_LSB = 0;

   typedef struct packed {
      logic [RGB_R_MSB-RGB_R_LSB:0] r;
      logic [RGB_G_MSB-RGB_G_LSB:0] g;
      logic [RGB_B_MSB-RGB_B_LSB:0] b;
   } rgb565_t;

endpackage
`default_nettype wire

// File: rtl/fb_bram_arbiter_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Interface : fb_bram_arbiter_if
// Brief     : Pixel-writer valid/ready port of the frame-buffer arbiter.
//             master = writer (pattern generator / CPU loader),
//             slave  = arbiter.
// Revision  : 1.0 - initial release
// ============================================================================
interface fb_bram_arbiter_if #(
   parameter int ADDR_W = fb_pkg::ADDR_W,
   parameter int DATA_W = fb_pkg::DATA_W
);

   logic              WR_VALID;
   logic              WR_READY;
   logic [ADDR_W-1:0] WR_ADDR;
   logic [DATA_W-1:0] WR_DATA;
   logic              WR_ERR;

   modport master (
      output WR_VALID,
      output WR_ADDR,
      output WR_DATA,
      input  WR_READY,
      input  WR_ERR
   );

   modport slave (
      input  WR_VALID,
      input  WR_ADDR,
      input  WR_DATA,
      output WR_READY,
      output WR_ERR
   );

endinterface
`default_nettype wire

// File: rtl/fb_scan_addr_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : fb_scan_addr_gen
// Brief    : VGA scan address generator. Tracks the pixel counter, line
//            counter and line base address from Vsync/Hsync/DE, and latches
//            the vertical-mirror mode once per frame so the image never tears.
// Revision : 1.0 - initial release
// ============================================================================
module fb_scan_addr_gen #(
   parameter int HSIZE  = fb_pkg::HSIZE,
   parameter int VSIZE  = fb_pkg::VSIZE,
   parameter int ADDR_W = fb_pkg::ADDR_W
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              Vsync,
   input  logic              Hsync,
   input  logic              DE,
   input  logic              Reverse_SW,
   output logic              scan_req,
   output logic [ADDR_W-1:0] scan_addr,
   output logic              frame_start
);
   import fb_pkg::*;

   localparam int HCNT_W = $clog2(HSIZE + 1);
   localparam int LINE_W = $clog2(VSIZE + 1);

   localparam logic [HCNT_W-1:0] C_HMAX      = HCNT_W'(HSIZE);
   localparam logic [LINE_W-1:0] C_VMAX      = LINE_W'(VSIZE);
   localparam logic [ADDR_W-1:0] C_HSTEP     = ADDR_W'(HSIZE);
   localparam logic [ADDR_W-1:0] C_BASE_LAST = ADDR_W'((VSIZE - 1) * HSIZE);

   logic [HCNT_W-1:0] r_hcnt;
   logic [LINE_W-1:0] r_line;
   logic [ADDR_W-1:0] r_base;
   logic              r_rev;
   logic              r_de_1d;
   logic              r_vsync_1d;
   logic              r_frame_start;

   // Edge-detect history for DE and Vsync, plus the registered frame-start pulse
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_de_1d       <= 1'b0;
         r_vsync_1d    <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_de_1d       <= DE;
         r_vsync_1d    <= Vsync;
         r_frame_start <= r_vsync_1d & ~Vsync;
      end
   end

   // Scan counters: frame start wins over end-of-line, which wins over Hsync/DE
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_hcnt <= '0;
         r_line <= '0;
         r_base <= '0;
         r_rev  <= 1'b0;
      end else if (!Vsync) begin
         // The new mode applies to this frame at once, so use the switch itself
         r_rev  <= Reverse_SW;
         r_base <= Reverse_SW ? C_BASE_LAST : '0;
         r_line <= '0;
         r_hcnt <= '0;
      end else if (r_de_1d && !DE) begin
         r_hcnt <= '0;
         // Past the last line the base is frozen; it is reloaded at next Vsync
         if (r_line < C_VMAX) begin
            r_line <= r_line + LINE_W'(1);
            r_base <= r_rev ? (r_base - C_HSTEP) : (r_base + C_HSTEP);
         end
      end else if (!Hsync) begin
         r_hcnt <= '0;
      end else if (DE && (r_hcnt < C_HMAX)) begin
         r_hcnt <= r_hcnt + HCNT_W'(1);
      end
   end

   // Scan claims the BRAM only inside the active area; overscan DE is dark
   always_comb begin
      scan_req  = DE && (r_hcnt < C_HMAX) && (r_line < C_VMAX);
      scan_addr = r_base + ADDR_W'(r_hcnt);
   end

   assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: rtl/fb_bram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : fb_bram_arbiter
// Brief    : Owns the single-port RGB565 frame-buffer BRAM. The VGA scan path
//            has absolute priority; a valid/ready pixel writer is served in
//            every cycle with DE low. Scan reads return through a two-stage
//            pipeline aligned with PIX_VALID.
// Revision : 1.0 - initial release
// ============================================================================
module fb_bram_arbiter #(
   parameter int HSIZE  = fb_pkg::HSIZE,
   parameter int VSIZE  = fb_pkg::VSIZE,
   parameter int ADDR_W = fb_pkg::ADDR_W,
   parameter int DATA_W = fb_pkg::DATA_W
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              Vsync,
   input  logic              Hsync,
   input  logic              DE,
   input  logic              Reverse_SW,
   fb_bram_arbiter_if.slave  wr_if,
   output logic              BRAM_EN,
   output logic              BRAM_WE,
   output logic [ADDR_W-1:0] BRAM_ADDR,
   output logic [DATA_W-1:0] BRAM_DIN,
   input  logic [DATA_W-1:0] BRAM_DOUT,
   output logic [DATA_W-1:0] PIX_DATA,
   output logic              PIX_VALID,
   output logic              FRAME_START
);
   import fb_pkg::*;

   // One extra bit so the full word count itself is representable
   localparam logic [ADDR_W:0] C_FB_WORDS = (ADDR_W + 1)'(HSIZE * VSIZE);

   logic              w_scan_req;
   logic [ADDR_W-1:0] w_scan_addr;
   logic              w_wr_fire;
   logic              w_wr_in_range;

   logic              r_bram_en;
   logic              r_bram_we;
   logic [ADDR_W-1:0] r_bram_addr;
   logic [DATA_W-1:0] r_bram_din;
   logic              r_wr_err;

   logic              r_scan_d1;
   logic              r_scan_d2;
   logic              r_de_d1;
   logic              r_de_d2;
   logic              r_pix_valid;
   logic [DATA_W-1:0] r_pix_data;

   fb_scan_addr_gen #(
      .HSIZE  (HSIZE),
      .VSIZE  (VSIZE),
      .ADDR_W (ADDR_W)
   ) u_scan_addr_gen (
      .CLK         (CLK),
      .RESET_N     (RESET_N),
      .Vsync       (Vsync),
      .Hsync       (Hsync),
      .DE          (DE),
      .Reverse_SW  (Reverse_SW),
      .scan_req    (w_scan_req),
      .scan_addr   (w_scan_addr),
      .frame_start (FRAME_START)
   );

   // Writer handshake: every DE cycle belongs to scan-out, even overscan ones
   always_comb begin
      wr_if.WR_READY = ~DE;
      w_wr_fire      = wr_if.WR_VALID & ~DE;
      w_wr_in_range  = ({1'b0, wr_if.WR_ADDR} < C_FB_WORDS);
   end

   // Grant mux: one BRAM operation per edge, scan before writer
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_bram_en   <= 1'b0;
         r_bram_we   <= 1'b0;
         r_bram_addr <= '0;
         r_bram_din  <= '0;
      end else begin
         r_bram_en <= 1'b0;
         r_bram_we <= 1'b0;
         if (w_scan_req) begin
            r_bram_en   <= 1'b1;
            r_bram_addr <= w_scan_addr;
         end else if (w_wr_fire && w_wr_in_range) begin
            r_bram_en   <= 1'b1;
            r_bram_we   <= 1'b1;
            r_bram_addr <= wr_if.WR_ADDR;
            r_bram_din  <= wr_if.WR_DATA;
         end
      end
   end

   // Sticky error: an accepted write that falls outside the frame is dropped
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_wr_err <= 1'b0;
      end else if (!w_scan_req && w_wr_fire && !w_wr_in_range) begin
         r_wr_err <= 1'b1;
      end
   end

   // Pixel pipeline: address at k, BRAM read at k+1, pixel registered at k+2
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_scan_d1   <= 1'b0;
         r_scan_d2   <= 1'b0;
         r_de_d1     <= 1'b0;
         r_de_d2     <= 1'b0;
         r_pix_valid <= 1'b0;
         r_pix_data  <= '0;
      end else begin
         r_scan_d1   <= w_scan_req;
         r_scan_d2   <= r_scan_d1;
         r_de_d1     <= DE;
         r_de_d2     <= r_de_d1;
         r_pix_valid <= r_de_d2;
         // Overscan and blanking slots never read the BRAM, so show black
         r_pix_data  <= r_scan_d2 ? BRAM_DOUT : '0;
      end
   end

   assign BRAM_EN      = r_bram_en;
   assign BRAM_WE      = r_bram_we;
   assign BRAM_ADDR    = r_bram_addr;
   assign BRAM_DIN     = r_bram_din;
   assign wr_if.WR_ERR = r_wr_err;
   assign PIX_DATA     = r_pix_data;
   assign PIX_VALID    = r_pix_valid;

endmodule
`default_nettype wire

// File: tb/tb_fb_bram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fb_bram_arbiter
// Brief    : Directed self-checking bench for fb_bram_arbiter. Uses full-width
//            lines (HSIZE=640) with a short 4-line frame and a behavioural
//            BRAM preloaded with data = addr[15:0].
// Revision : 1.0 - initial release
// ============================================================================
module tb_fb_bram_arbiter;

   localparam int HSIZE  = 640;
   localparam int VSIZE  = 4;
   localparam int ADDR_W = 19;
   localparam int DATA_W = 16;
   localparam int WORDS  = HSIZE * VSIZE;
   localparam logic [ADDR_W-1:0] WORDS_A = ADDR_W'(WORDS);

   logic              CLK        = 1'b0;
   logic              RESET_N    = 1'b0;
   logic              Vsync      = 1'b1;
   logic              Hsync      = 1'b1;
   logic              DE         = 1'b0;
   logic              Reverse_SW = 1'b0;
   logic              BRAM_EN;
   logic              BRAM_WE;
   logic [ADDR_W-1:0] BRAM_ADDR;
   logic [DATA_W-1:0] BRAM_DIN;
   logic [DATA_W-1:0] BRAM_DOUT = '0;
   logic [DATA_W-1:0] PIX_DATA;
   logic              PIX_VALID;
   logic              FRAME_START;

   fb_bram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wr_if ();

   fb_bram_arbiter #(
      .HSIZE  (HSIZE),
      .VSIZE  (VSIZE),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) dut (
      .CLK         (CLK),
      .RESET_N     (RESET_N),
      .Vsync       (Vsync),
      .Hsync       (Hsync),
      .DE          (DE),
      .Reverse_SW  (Reverse_SW),
      .wr_if       (wr_if),
      .BRAM_EN     (BRAM_EN),
      .BRAM_WE     (BRAM_WE),
      .BRAM_ADDR   (BRAM_ADDR),
      .BRAM_DIN    (BRAM_DIN),
      .BRAM_DOUT   (BRAM_DOUT),
      .PIX_DATA    (PIX_DATA),
      .PIX_VALID   (PIX_VALID),
      .FRAME_START (FRAME_START)
   );

   always #5 CLK = ~CLK;

   // Behavioural single-port BRAM, read data one cycle after an enabled read
   logic [15:0] mem [0:WORDS-1];
   initial begin
      for (int i = 0; i < WORDS; i++) mem[i] = 16'(i);
   end
   always @(posedge CLK) begin
      if (BRAM_EN && (BRAM_ADDR < WORDS_A)) begin
         if (BRAM_WE) mem[BRAM_ADDR[11:0]] <= BRAM_DIN;
         else         BRAM_DOUT <= mem[BRAM_ADDR[11:0]];
      end
   end

   // Bookkeeping
   int          n_cmp = 0;
   int          n_err = 0;
   int          cur_line = 0;
   int          rd_cnt   [0:7];
   int          pix_cnt  [0:7];
   logic [18:0] first_rd [0:7];
   logic [18:0] last_rd  [0:7];
   logic [15:0] first_pix[0:7];
   logic [15:0] probe_pix[0:7];
   int          probe_idx = 360;
   int          wr_in_de = 0;
   int          ready_bad = 0;
   int          sup_bad = 0;
   logic        de_prev = 1'b0;
   logic        fs1, fs2;
   logic        lat_chk = 1'b0;
   logic        resume_chk = 1'b0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Observe outputs on the falling edge, between active edges
   always @(negedge CLK) begin
      if (BRAM_EN && !BRAM_WE) begin
         if (rd_cnt[cur_line] == 0) first_rd[cur_line] = BRAM_ADDR;
         last_rd[cur_line] = BRAM_ADDR;
         rd_cnt[cur_line]++;
      end
      if (BRAM_EN && BRAM_WE && de_prev) wr_in_de++;
      if (wr_if.WR_READY !== ~DE) ready_bad++;
      if (PIX_VALID) begin
         if (pix_cnt[cur_line] == 0) first_pix[cur_line] = PIX_DATA;
         if (pix_cnt[cur_line] == probe_idx) probe_pix[cur_line] = PIX_DATA;
         if (pix_cnt[cur_line] >= HSIZE && PIX_DATA != 16'h0) sup_bad++;
         pix_cnt[cur_line]++;
      end
      de_prev = DE;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic clear_stats();
      for (int i = 0; i < 8; i++) begin
         rd_cnt[i]    = 0;
         pix_cnt[i]   = 0;
         first_rd[i]  = '1;
         last_rd[i]   = '1;
         first_pix[i] = '1;
         probe_pix[i] = '1;
      end
      wr_in_de  = 0;
      ready_bad = 0;
      sup_bad   = 0;
   endtask

   task automatic do_line(input int idx, input int de_len);
      cur_line = idx;
      Hsync = 1'b0;
      tick(8);
      Hsync = 1'b1;
      tick(8);
      DE = 1'b1;
      for (int j = 0; j < de_len; j++) begin
         tick(1);
         if (lat_chk && idx == 0 && j == 1) check_val("pix_valid_k+1", 64'(PIX_VALID), 64'(0));
         if (lat_chk && idx == 0 && j == 2) check_val("pix_valid_k+2", 64'(PIX_VALID), 64'(1));
      end
      DE = 1'b0;
      tick(1);
      if (resume_chk) check_val("wr_resume_first_blank", 64'({BRAM_WE, BRAM_ADDR}), 64'({1'b1, 19'd1000}));
      tick(8);
   endtask

   task automatic do_frame(input int de_len0, input int toggle_line, input logic toggle_val);
      clear_stats();
      Vsync = 1'b0;
      tick(1);
      fs1 = FRAME_START;
      tick(1);
      fs2 = FRAME_START;
      tick(2);
      Vsync = 1'b1;
      tick(4);
      for (int i = 0; i < VSIZE; i++) begin
         if (i == toggle_line) Reverse_SW = toggle_val;
         do_line(i, (i == 0) ? de_len0 : HSIZE);
      end
   endtask

   initial begin
      wr_if.WR_VALID = 1'b0;
      wr_if.WR_ADDR  = '0;
      wr_if.WR_DATA  = '0;

      // Reset state
      tick(3);
      check_val("reset_outputs",
                64'({BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DIN, PIX_DATA, PIX_VALID, FRAME_START, wr_if.WR_ERR}),
                64'(0));
      RESET_N = 1'b1;
      tick(3);

      // Normal scan
      lat_chk = 1'b1;
      do_frame(HSIZE, -1, 1'b0);
      lat_chk = 1'b0;
      check_val("frame_start_pulse", 64'(fs1), 64'(1));
      check_val("frame_start_one_cycle", 64'(fs2), 64'(0));
      check_val("norm_l0_first_rd", 64'(first_rd[0]), 64'(0));
      check_val("norm_l0_first_pix", 64'(first_pix[0]), 64'(16'h0000));
      check_val("norm_l1_first_pix", 64'(first_pix[1]), 64'(16'h0280));
      check_val("norm_l0_rd_cnt", 64'(rd_cnt[0]), 64'(640));
      check_val("norm_l1_pix_cnt", 64'(pix_cnt[1]), 64'(640));
      check_val("norm_l3_first_rd", 64'(first_rd[3]), 64'(1920));
      check_val("norm_l1_probe", 64'(probe_pix[1]), 64'(16'h03E8));

      // Mirrored scan; switch released before line 2 must not matter
      Reverse_SW = 1'b1;
      do_frame(HSIZE, 2, 1'b0);
      check_val("rev_l0_first_rd", 64'(first_rd[0]), 64'(1920));
      check_val("rev_l0_first_pix", 64'(first_pix[0]), 64'(16'h0780));
      check_val("rev_l1_first_rd", 64'(first_rd[1]), 64'(1280));
      check_val("rev_l2_first_rd", 64'(first_rd[2]), 64'(640));
      check_val("rev_l3_first_rd", 64'(first_rd[3]), 64'(0));

      // Switch change takes effect at the next frame
      do_frame(HSIZE, -1, 1'b0);
      check_val("next_l0_first_rd", 64'(first_rd[0]), 64'(0));
      check_val("next_l3_first_rd", 64'(first_rd[3]), 64'(1920));

      // Writer held valid across a whole frame
      wr_if.WR_VALID = 1'b1;
      wr_if.WR_ADDR  = 19'd1000;
      wr_if.WR_DATA  = 16'hF800;
      resume_chk = 1'b1;
      do_frame(HSIZE, -1, 1'b0);
      resume_chk = 1'b0;
      check_val("wr_no_write_in_de", 64'(wr_in_de), 64'(0));
      check_val("wr_ready_is_not_de", 64'(ready_bad), 64'(0));
      check_val("wr_readback_1000", 64'(probe_pix[1]), 64'(16'hF800));
      check_val("wr_err_clear", 64'(wr_if.WR_ERR), 64'(0));

      // Overscan: DE held 700 cycles on line 0, writer still requesting
      do_frame(700, -1, 1'b0);
      check_val("ovs_rd_cnt", 64'(rd_cnt[0]), 64'(640));
      check_val("ovs_last_rd", 64'(last_rd[0]), 64'(639));
      check_val("ovs_pix_cnt", 64'(pix_cnt[0]), 64'(700));
      check_val("ovs_black", 64'(sup_bad), 64'(0));
      check_val("ovs_no_grant", 64'(wr_in_de), 64'(0));
      check_val("ovs_l1_first_pix", 64'(first_pix[1]), 64'(16'h0280));
      wr_if.WR_VALID = 1'b0;
      tick(2);

      // Out-of-range write
      wr_if.WR_ADDR  = 19'd307200;
      wr_if.WR_VALID = 1'b1;
      check_val("oor_ready", 64'(wr_if.WR_READY), 64'(1));
      tick(1);
      wr_if.WR_VALID = 1'b0;
      check_val("oor_no_bram_en", 64'(BRAM_EN), 64'(0));
      check_val("oor_err_set", 64'(wr_if.WR_ERR), 64'(1));
      tick(20);
      check_val("oor_err_sticky", 64'(wr_if.WR_ERR), 64'(1));
      wr_if.WR_ADDR  = 19'd5;
      wr_if.WR_DATA  = 16'h1234;
      wr_if.WR_VALID = 1'b1;
      tick(1);
      wr_if.WR_VALID = 1'b0;
      check_val("inrange_after_oor", 64'({BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DIN}),
                64'({1'b1, 1'b1, 19'd5, 16'h1234}));
      check_val("oor_err_kept", 64'(wr_if.WR_ERR), 64'(1));

      // Reset pulsed in the middle of an active line
      Vsync = 1'b0;
      tick(2);
      Vsync = 1'b1;
      tick(4);
      Hsync = 1'b0;
      tick(8);
      Hsync = 1'b1;
      tick(8);
      DE = 1'b1;
      tick(100);
      check_val("pre_reset_scanning", 64'({BRAM_EN, PIX_VALID}), 64'(2'b11));
      #2;
      RESET_N = 1'b0;
      #1;
      check_val("async_reset_outputs",
                64'({BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DIN, PIX_DATA, PIX_VALID, FRAME_START, wr_if.WR_ERR}),
                64'(0));
      tick(2);
      DE = 1'b0;
      tick(2);
      RESET_N = 1'b1;
      tick(4);
      do_frame(HSIZE, -1, 1'b0);
      check_val("rst_frame_start", 64'(fs1), 64'(1));
      check_val("rst_l0_first_rd", 64'(first_rd[0]), 64'(0));
      check_val("rst_l1_first_pix", 64'(first_pix[1]), 64'(16'h0280));
      check_val("rst_l3_rd_cnt", 64'(rd_cnt[3]), 64'(640));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fb_bram_arbiter.md
Name: fb_bram_arbiter

Overview:
- Owns the single-port frame-buffer BRAM (RGB565, one pixel per word).
- Shares the BRAM between two requesters:
  - the VGA scan-out path, which generates addresses from Vsync, Hsync and DE and has absolute priority;
  - a pixel writer (test pattern or CPU loader), served over a valid/ready handshake in cycles the scan path does not claim.
- Normal or vertically reversed scan order is latched once per frame, so a mid-frame switch cannot tear the image.

Parameters:
- HSIZE, 640: active pixels per line.
- VSIZE, 480: active lines per frame.
- ADDR_W, 19: BRAM address width; must satisfy HSIZE*VSIZE <= 2**ADDR_W.
- DATA_W, 16: pixel/BRAM word width.

Ports:
- CLK  in  1  pixel clock; the BRAM runs on this clock.
- RESET_N  in  1  asynchronous, active-low reset.
- Vsync  in  1  active-low vertical sync.
- Hsync  in  1  active-low horizontal sync.
- DE  in  1  active-high display enable.
- Reverse_SW  in  1  1 = bottom line first (vertically mirrored).
- WR_VALID  in  1  writer request.
- WR_READY  out  1  writer may transfer this cycle.
- WR_ADDR  in  ADDR_W  linear pixel address (y*HSIZE+x).
- WR_DATA  in  DATA_W  pixel to write.
- WR_ERR  out  1  sticky: an out-of-range write was dropped.
- BRAM_EN  out  1  BRAM enable (registered).
- BRAM_WE  out  1  BRAM write enable (registered).
- BRAM_ADDR  out  ADDR_W  BRAM address (registered).
- BRAM_DIN  out  DATA_W  BRAM write data (registered).
- BRAM_DOUT  in  DATA_W  BRAM read data; valid 1 cycle after an enabled read.
- PIX_DATA  out  DATA_W  pixel to the VGA encoder.
- PIX_VALID  out  1  DE delayed by 2 cycles.
- FRAME_START  out  1  1-cycle pulse on the first Vsync-low cycle.

Behaviour:
- Reset: all outputs 0. Internal state also 0: hcnt, line counter, line base, rev latch, DE1d, Vsync1d, the pipeline flops.
- Frame start (Vsync=0, sampled each edge):
  - rev <= Reverse_SW.
  - base <= Reverse_SW ? (VSIZE-1)*HSIZE : 0 (uses Reverse_SW directly, not the old rev).
  - line <= 0, hcnt <= 0.
  - FRAME_START pulses 1 cycle on the Vsync 1->0 transition.
- Hsync=0: hcnt <= 0.
- DE=1: hcnt <= hcnt+1, saturating at HSIZE.
- DE falling edge (DE1d=1, DE=0):
  - hcnt <= 0, line <= line+1 (saturating at VSIZE);
  - base <= rev ? base-HSIZE : base+HSIZE.
  - No underflow or overflow can occur while line < VSIZE; base is not updated once line = VSIZE.
  - A falling edge coinciding with Vsync=0 takes the frame-start values.
- Arbitration: exactly one BRAM operation per edge, decided from values sampled at that edge.
  - Priority 1, scan: DE=1 and hcnt<HSIZE and line<VSIZE. Result: BRAM_EN=1, BRAM_WE=0, BRAM_ADDR=base+hcnt.
  - Priority 2, write: WR_VALID & WR_READY.
    - WR_ADDR < HSIZE*VSIZE: BRAM_EN=1, BRAM_WE=1, ADDR/DIN from the writer.
    - Otherwise: the transfer completes (handshake consumed), no BRAM access, WR_ERR <= 1. WR_ERR is cleared only by reset.
  - Otherwise: BRAM_EN=0, BRAM_WE=0; ADDR/DIN hold their previous values.
- WR_READY = ~DE (combinational). The writer never stalls scan-out. Writes are served in blanking and when DE=0 mid-line.
- Scan read pipeline, for DE sampled at edge k:
  - BRAM access in cycle k+1;
  - PIX_DATA registered at edge k+2 from BRAM_DOUT;
  - PIX_VALID tracks DE with a 2-cycle delay.
- Suppressed scan cycles (DE=1 with hcnt=HSIZE or line=VSIZE): PIX_DATA=0 (black) with PIX_VALID=1. These cycles are not granted to the writer.
- Reverse_SW toggles mid-frame: no effect until the next Vsync low.
- Reset asserted mid-operation: outputs clear immediately (asynchronous reset). A BRAM_WE pulse already registered for this cycle is cancelled.

Decomposition:
- Package fb_pkg: HSIZE, VSIZE, FB_WORDS=HSIZE*VSIZE, ADDR_W, DATA_W, and the RGB565 field slices (R [15:11], G [10:5], B [4:0]).
- One natural sub-module, fb_scan_addr_gen: the hcnt, line and base counters plus the rev latch. It outputs a scan request and scan address to the arbiter top, which owns the grant mux, BRAM registers and pixel pipeline.

Test Plan:
- Normal scan, 640x480 timing, BRAM preloaded with data=addr[15:0]:
  - first PIX_VALID pixel of line 0 = 0x0000, of line 1 = 640 (0x0280);
  - PIX_VALID rises 2 cycles after DE.
- Reverse_SW=1 before Vsync:
  - line 0 first read address = 306560;
  - line 479 first read address = 0;
  - toggling Reverse_SW mid-frame changes nothing until the next frame.
- Writer holds WR_VALID=1 across a line:
  - WR_READY=0 throughout DE=1 and the BRAM shows no write cycles during DE;
  - writes resume on the first DE=0 cycle;
  - write 0xF800 to address 1000, then check a scan read of address 1000 returns 0xF800.
- WR_ADDR=307200 with WR_VALID:
  - handshake completes, no BRAM_EN, WR_ERR=1 and stays 1 until RESET_N.
- DE held 700 cycles:
  - reads issued for hcnt 0..639 only;
  - pixels 640..699 output as 0 with PIX_VALID=1;
  - no writer grant during those cycles.
- RESET_N pulsed low mid-line:
  - all outputs 0 asynchronously;
  - after release, the scan restarts correctly from the next Vsync.
